// File: rtl/axis_skid_fifo_if.sv
// AXI4-Stream beat bundle used on both sides of the skid FIFO.
// Master drives data/keep/valid; slave returns ready.
interface axis_skid_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_skid_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with registered outputs.
// Head beat lives in the output register; the array holds the rest.
module axis_skid_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter bit DROP_NULL  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    axis_skid_fifo_if.slave         s_axis,
    axis_skid_fifo_if.master        m_axis,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = DATA_WIDTH + KW;

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_head;
    logic          r_m_valid;
    logic          r_s_ready;

    logic          w_keep_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_mem_empty;
    logic          w_mem_rd;
    logic          w_mem_wr;
    logic          w_bypass;
    logic [CW-1:0] w_mem_cnt;
    logic [CW-1:0] w_count_nxt;
    logic [BW-1:0] w_in_beat;

    assign w_in_beat   = {s_axis.tkeep, s_axis.tdata};
    assign w_keep_ok   = !DROP_NULL || (|s_axis.tkeep);
    assign w_push      = s_axis.tvalid & r_s_ready & w_keep_ok;
    assign w_pop       = r_m_valid & m_axis.tready;
    // Output register needs a new head when empty or being consumed.
    assign w_load      = !r_m_valid | w_pop;
    assign w_mem_cnt   = r_count - CW'(r_m_valid);
    assign w_mem_empty = (w_mem_cnt == '0);
    assign w_mem_rd    = w_load & !w_mem_empty;
    // Nothing queued behind the head: incoming beat goes straight out.
    assign w_bypass    = w_load & w_mem_empty & w_push;
    assign w_mem_wr    = w_push & !w_bypass;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Storage array write; contents need no reset since pointers do.
    always_ff @(posedge clock) begin
        if (reset && w_mem_wr) begin
            r_mem[r_wptr] <= w_in_beat;
        end
    end

    // Pointers, occupancy, registered ready and output head register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_head    <= '0;
        end else begin
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt < CW'(DEPTH));
            if (w_mem_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_mem_rd) begin
                r_head    <= r_mem[r_rptr];
                r_rptr    <= r_rptr + AW'(1);
                r_m_valid <= 1'b1;
            end else if (w_bypass) begin
                r_head    <= w_in_beat;
                r_m_valid <= 1'b1;
            end else if (w_load) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = r_head[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = r_head[BW-1:DATA_WIDTH];
    assign m_axis.tvalid = r_m_valid;
    assign s_axis.tready = r_s_ready;
    assign occupancy     = r_count;
endmodule

// File: tb/tb_axis_skid_fifo.sv
// Bench for axis_skid_fifo: two instances (null drop on / off) share
// stimulus; each is compared every cycle against a queue model.
module tb_axis_skid_fifo;
    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic          out_ready = 1'b1;

    int chk_m = 0;
    int err_m = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit DROP = (g == 0);

        axis_skid_fifo_if #(.DATA_WIDTH(DW)) s_if ();
        axis_skid_fifo_if #(.DATA_WIDTH(DW)) m_if ();
        logic [CW-1:0] occ;

        assign s_if.tdata  = in_data;
        assign s_if.tkeep  = in_keep;
        assign s_if.tvalid = in_valid;
        assign m_if.tready = out_ready;

        axis_skid_fifo #(
            .DATA_WIDTH(DW),
            .DEPTH     (DEPTH),
            .DROP_NULL (DROP)
        ) dut (
            .clock    (clock),
            .reset    (reset),
            .s_axis   (s_if),
            .m_axis   (m_if),
            .occupancy(occ)
        );

        logic [DW+KW-1:0] q[$];
        logic [DW+KW-1:0] log_q[$];
        logic [DW+KW-1:0] last = '0;
        bit               rdy = 1'b0;
        bit               hs;
        bit               pop;
        int               nchk = 0;
        int               nerr = 0;

        task automatic chk(input string nm, input logic [63:0] a,
                           input logic [63:0] e);
            nchk++;
            if (a !== e) begin
                nerr++;
                $display("FAIL i%0d %s got %h exp %h", g, nm, a, e);
            end
        endtask

        // Model: the FIFO is just a queue; M shows its head, ready is
        // "fewer than DEPTH stored" after the edge.
        always begin
            @(posedge clock);
            if (!reset) begin
                q.delete();
                rdy  = 1'b0;
                last = '0;
            end else begin
                pop = (q.size() > 0) && out_ready;
                hs  = in_valid && rdy;
                if (pop) begin
                    log_q.push_back(q[0]);
                    void'(q.pop_front());
                end
                if (hs && !(DROP && in_keep == '0)) begin
                    q.push_back({in_keep, in_data});
                end
                rdy = (q.size() < DEPTH);
            end
            if (q.size() > 0) last = q[0];
            #1;
            chk("tvalid", 64'(m_if.tvalid), 64'(q.size() > 0));
            chk("s_tready", 64'(s_if.tready), 64'(rdy));
            chk("occupancy", 64'(occ), 64'(q.size()));
            chk("occ_bound", 64'(occ <= CW'(DEPTH)), 64'(1));
            chk("beat", 64'({m_if.tkeep, m_if.tdata}), 64'(last));
        end
    end

    function automatic logic [63:0] bt(input logic [3:0] k,
                                       input logic [31:0] d);
        return 64'({k, d});
    endfunction

    task automatic mchk(input string nm, input logic [63:0] a,
                        input logic [63:0] e);
        chk_m++;
        if (a !== e) begin
            err_m++;
            $display("FAIL %s got %h exp %h", nm, a, e);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k);
        bit ok;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        for (int t = 0; t < 50 && !done; t++) begin
            ok = g_inst[0].rdy && g_inst[1].rdy;
            @(negedge clock);
            done = ok;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_keep  = 4'($urandom);
        if (!done) begin
            chk_m++;
            err_m++;
            $display("FAIL send_timeout data %h", d);
        end
    endtask

    task automatic push_chk(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = 4'hF;
        @(posedge clock);
        #2;
        mchk("p1_valid", 64'(g_inst[0].m_if.tvalid), 64'(1));
        mchk("p1_data", 64'(g_inst[0].m_if.tdata), 64'(d));
        mchk("p1_occ", 64'(g_inst[0].occ), 64'(1));
        @(negedge clock);
    endtask

    initial begin
        int b0;
        int b1;
        int acc1;
        int st0;
        int cyc;

        // Reset and basic pass-through.
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        mchk("rst_ready", 64'(g_inst[0].s_if.tready), 64'(0));
        mchk("rst_occ", 64'(g_inst[0].occ), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        mchk("ready_up", 64'(g_inst[0].s_if.tready), 64'(1));
        b0 = g_inst[0].log_q.size();
        push_chk(32'h0000_0000);
        push_chk(32'h0102_0304);
        push_chk(32'hFFFF_FFFF);
        idle(3);
        mchk("p1_count", 64'(g_inst[0].log_q.size() - b0), 64'(3));
        mchk("p1_o0", 64'(g_inst[0].log_q[b0]), bt(4'hF, 32'h0));
        mchk("p1_o1", 64'(g_inst[0].log_q[b0+1]), bt(4'hF, 32'h0102_0304));
        mchk("p1_o2", 64'(g_inst[0].log_q[b0+2]), bt(4'hF, 32'hFFFF_FFFF));

        // Fill while stalled, then drain with pointer wrap.
        b0 = g_inst[0].log_q.size();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 4'hF);
        in_valid = 1'b1;
        in_data  = 32'h14;
        in_keep  = 4'hF;
        repeat (2) @(negedge clock);
        mchk("full_occ", 64'(g_inst[0].occ), 64'(4));
        mchk("full_model", 64'(g_inst[0].q.size()), 64'(4));
        mchk("full_ready", 64'(g_inst[0].s_if.tready), 64'(0));
        mchk("full_valid", 64'(g_inst[0].m_if.tvalid), 64'(1));
        mchk("full_head", 64'(g_inst[0].m_if.tdata), 64'(32'h10));
        out_ready = 1'b1;
        send(32'h14, 4'hF);
        send(32'h15, 4'hF);
        idle(6);
        mchk("drain_count", 64'(g_inst[0].log_q.size() - b0), 64'(6));
        for (int i = 0; i < 6; i++) begin
            mchk("drain_o", 64'(g_inst[0].log_q[b0+i]),
                 bt(4'hF, 32'h10 + 32'(i)));
        end

        // Null beats: dropped by instance 0, kept by instance 1.
        b0 = g_inst[0].log_q.size();
        b1 = g_inst[1].log_q.size();
        send(32'hAAAA_AAAA, 4'hF);
        send(32'hBBBB_BBBB, 4'h0);
        send(32'hCCCC_CCCC, 4'h3);
        idle(4);
        mchk("drop_count", 64'(g_inst[0].log_q.size() - b0), 64'(2));
        mchk("drop_o0", 64'(g_inst[0].log_q[b0]), bt(4'hF, 32'hAAAA_AAAA));
        mchk("drop_o1", 64'(g_inst[0].log_q[b0+1]), bt(4'h3, 32'hCCCC_CCCC));
        mchk("keep_count", 64'(g_inst[1].log_q.size() - b1), 64'(3));
        mchk("keep_o1", 64'(g_inst[1].log_q[b1+1]), bt(4'h0, 32'hBBBB_BBBB));

        // Reset with beats stored and M stalled.
        out_ready = 1'b0;
        send(32'h1, 4'hF);
        send(32'h2, 4'hF);
        send(32'h3, 4'hF);
        mchk("pre_rst_occ", 64'(g_inst[0].occ), 64'(3));
        reset = 1'b0;
        @(negedge clock);
        mchk("mid_rst_valid", 64'(g_inst[0].m_if.tvalid), 64'(0));
        mchk("mid_rst_occ", 64'(g_inst[0].occ), 64'(0));
        mchk("mid_rst_ready", 64'(g_inst[1].s_if.tready), 64'(0));
        reset = 1'b1;
        b0 = g_inst[0].log_q.size();
        out_ready = 1'b1;
        @(negedge clock);
        send(32'h55, 4'hF);
        idle(4);
        mchk("post_rst_count", 64'(g_inst[0].log_q.size() - b0), 64'(1));
        mchk("post_rst_o0", 64'(g_inst[0].log_q[b0]), bt(4'hF, 32'h55));

        // Random traffic with random back-pressure.
        b0 = g_inst[0].log_q.size();
        b1 = g_inst[1].log_q.size();
        acc1 = 0;
        st0 = 0;
        cyc = 0;
        while (acc1 < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_keep   = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && g_inst[1].rdy) acc1++;
            if (in_valid && g_inst[0].rdy && in_keep != '0) st0++;
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b1;
        idle(12);
        mchk("rand_accepted", 64'(acc1), 64'(1000));
        mchk("rand_out1", 64'(g_inst[1].log_q.size() - b1), 64'(acc1));
        mchk("rand_out0", 64'(g_inst[0].log_q.size() - b0), 64'(st0));
        mchk("rand_empty0", 64'(g_inst[0].occ), 64'(0));
        mchk("rand_empty1", 64'(g_inst[1].occ), 64'(0));

        $display("CHECKS %0d ERRORS %0d",
                 chk_m + g_inst[0].nchk + g_inst[1].nchk,
                 err_m + g_inst[0].nerr + g_inst[1].nerr);
        $finish;
    end
endmodule

// File: doc/axis_skid_fifo.md
Name: axis_skid_fifo

Overview:
- Small synchronous AXI4-Stream FIFO placed directly upstream of the byte-increment stage; its master port drives that stage's S_AXIS.
- Decouples upstream tvalid from downstream tready, so the combinational ready path through the increment stage never reaches the source.
- Optionally discards null beats (tkeep all zero) so the increment stage never sees them.
- First-word-fall-through, registered outputs, single clock domain.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- DEPTH, 4, storage entries; power of two, minimum 2.
- DROP_NULL, 1, when 1 a beat with tkeep == 0 is accepted and discarded; when 0 it is stored like any other beat.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the clock edge.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tkeep  in  DATA_WIDTH/8  slave byte qualifiers.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready; registered.
- m_axis_tdata  out  DATA_WIDTH  master data; registered.
- m_axis_tkeep  out  DATA_WIDTH/8  master byte qualifiers; registered.
- m_axis_tvalid  out  1  master valid; registered.
- m_axis_tready  in  1  master ready.
- occupancy  out  clog2(DEPTH)+1  number of stored beats, including the one presented on M.

Behaviour:
- Reset (reset == 0 at an edge):
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, occupancy = 0.
  - Read and write pointers are cleared; any stored data is lost.
- After reset: s_axis_tready rises one cycle after the first edge with reset == 1.
- Push (s_axis_tvalid & s_axis_tready at an edge):
  - Stores {tdata, tkeep}, unless DROP_NULL == 1 and tkeep == 0; a dropped beat is still handshaken and leaves occupancy unchanged.
- Pop (m_axis_tvalid & m_axis_tready at an edge): removes the head entry.
- Latency: a beat pushed into an empty FIFO appears on m_axis_tvalid / tdata one edge later (1 cycle).
- Throughput: one beat per cycle sustained when m_axis_tready is held high.
- Counting: occupancy(next) = occupancy + push_stored − pop. Simultaneous push and pop leaves occupancy unchanged, and the data ordering remains strict FIFO.
- Ready: s_axis_tready(next) = 1 iff occupancy(next) < DEPTH.
  - Registered, so it is 0 in the cycle after the FIFO becomes full.
  - A pop while full raises tready on the next cycle; no same-cycle pass-through.
- Full: no write while s_axis_tready = 0. Pointers never overrun.
- Empty:
  - m_axis_tvalid = 0.
  - m_axis_tdata / m_axis_tkeep hold their last values; they are not reloaded with junk.
- AXIS stability: while m_axis_tvalid & !m_axis_tready, m_axis_tdata and m_axis_tkeep do not change and tvalid does not drop.
- Pointers: clog2(DEPTH)-bit read/write indices wrap modulo DEPTH. Full/empty state is taken from occupancy, not from pointer equality.
- Reset mid-stream (reset low while beats are stored or M is stalled):
  - The next edge forces the reset values above.
  - No stored beat is emitted after reset is released.
- Unknowns: s_axis_tdata / tkeep are ignored whenever s_axis_tvalid = 0.

Test Plan:
- Basic pass-through: reset low 3 cycles, then high; m_axis_tready = 1; push 0x00000000, 0x01020304, 0xFFFFFFFF with tkeep = 0xF -> same three words on M in order, each 1 cycle after its push; occupancy peaks at 1.
- Fill and stall: m_axis_tready = 0; drive 6 consecutive beats 0x10..0x15 -> exactly 4 accepted; s_axis_tready = 0 from the cycle after the 4th; occupancy = 4; M holds 0x10 stable.
- Drain with wrap: from the full state, raise m_axis_tready while still offering 0x14, 0x15 -> output sequence 0x10..0x15 with no loss or duplication; pointers wrap past index 3.
- Null drop: DROP_NULL = 1; push 0xAAAAAAAA/0xF, 0xBBBBBBBB/0x0, 0xCCCCCCCC/0x3 -> M emits only 0xAAAAAAAA/0xF then 0xCCCCCCCC/0x3. Rerun with DROP_NULL = 0 -> all three emitted.
- Reset mid-operation: with 3 beats stored and m_axis_tready = 0, pull reset low 1 cycle -> m_axis_tvalid = 0, occupancy = 0, s_axis_tready = 0; after release the next pushed word 0x55 is the first word out.
- Random back-pressure: 1000 random beats with random s_axis_tvalid and m_axis_tready -> scoreboard shows exact in-order match; tdata/tkeep stable under stall; occupancy never exceeds DEPTH.
